irq_priority_encoder: RTL
=========================

Name: irq_priority_encoder

Overview:
- Sequential 8-to-3 priority encoder with an acknowledge handshake. It is the inverse of the CPU's 3-to-8 one-hot decode path.
- Captures rising edges on 8 request lines into a pending register and presents the highest-priority unmasked pending request as a 3-bit code with a valid flag.
- Holds the code stable until the CPU control unit acknowledges it.
- Sits between peripheral request lines and the CPU control unit.

Parameters:
- MSB_FIRST, 0, priority order: 0 = bit 0 highest (code 3'b000 wins); 1 = bit 7 highest.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  8  request lines, level inputs; a 0->1 transition is one event
- mask  input  8  1 = request bit excluded from selection (still captured into pending)
- enable  input  1  1 = new codes may be presented; 0 = no new presentation
- ack  input  1  one-cycle acknowledge of the presented code
- code  output  3  encoded index of the presented request
- valid  output  1  code is valid and held
- pending  output  8  captured, not-yet-acknowledged events

Behaviour:
- Reset (rst=1 at a clk edge):
  - code=3'b000, valid=0, pending=8'h00, state=IDLE.
  - The edge register loads the current req, so lines held high through reset generate no event.
- Edge capture, every cycle when not in reset:
  - edge = req & ~req_q; req_q <= req.
  - pending <= (pending & ~clr) | edge, where clr is the one-hot of code when ack is accepted, else 0.
  - Set wins: an edge on the bit being cleared in the same cycle leaves that bit pending.
- Selection:
  - cand = pending & ~mask.
  - MSB_FIRST=0: lowest set index wins. MSB_FIRST=1: highest set index wins.
  - Selection is taken from the registered pending only; the same-cycle edge is not included.
- FSM states: IDLE, PRESENT, GAP.
  - IDLE: if enable=1 and cand!=0 -> code<=selected index, valid<=1, go to PRESENT. Otherwise stay, valid=0, code holds its last value.
  - PRESENT: valid=1, code frozen. Changes to mask or enable, and new edges, do not alter code or withdraw valid. On ack=1 -> clear pending[code], valid<=0, go to GAP.
  - GAP: valid=0 for exactly one cycle -> IDLE. This guarantees a valid low pulse between back-to-back codes, even for the same index.
- Ack outside PRESENT (in IDLE or GAP) is ignored and has no side effects.
- Latency:
  - req rises, sampled at edge N -> pending bit set after edge N -> valid=1 after edge N+1, provided the FSM is IDLE and enable=1.
  - ack sampled at edge M -> valid=0 after M. The earliest next valid is after M+2.
- Multiple simultaneous edges: all are captured in one cycle and served one per handshake in priority order.
- A request held high produces exactly one event; it must fall and rise again to re-request.
- Masked pending bits stay pending indefinitely and become eligible once unmasked.
- Mid-operation reset:
  - Abandons PRESENT. valid=0 and pending=0 on the next cycle.
  - Requests still high after reset are not re-captured.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset with req=8'h04 held high, then release rst -> pending stays 8'h00 and valid stays 0 for 10 cycles.
- enable=1, mask=0: req bits 5 and 2 rise in the same cycle -> two cycles later valid=1, code=3'd2, pending=8'h24. After ack: valid low for 2 cycles, then code=3'd5. After the second ack: pending=8'h00.
- MSB_FIRST=1, same stimulus -> code=3'd5 first, then 3'd2.
- In PRESENT with code=3'd3, assert ack in the same cycle as a new rising edge on req[3] -> pending[3] remains 1. valid drops for 2 cycles, then re-presents code=3'd3.
- mask=8'h01, req[0] and req[7] rise -> code=3'd7 only; pending[0] stays 1. Clear mask -> after the ack of 7 completes, code=3'd0 is presented.
- enable=0 with pending=8'h10 -> valid stays 0; ack pulses are ignored and pending stays 8'h10. Set enable=1 -> valid=1, code=3'd4 on the next cycle. Assert rst during PRESENT -> valid=0, pending=8'h00 on the following cycle.

Source files
------------

// File: rtl/irq_priority_encoder.sv
// Sequential 8-to-3 interrupt priority encoder. Rising request edges are latched
// into a pending register; the winning unmasked bit is presented until acknowledged.
module irq_priority_encoder #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] mask,
    input  logic       enable,
    input  logic       ack,
    output logic [2:0] code,
    output logic       valid,
    output logic [7:0] pending
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } state_t;

    state_t     state_q;
    logic [7:0] req_q;
    logic [7:0] pend_q;
    logic [7:0] pend_d;
    logic [2:0] code_q;
    logic       valid_q;

    logic [7:0] req_edge;
    logic [7:0] clr;
    logic [7:0] cand;
    logic [2:0] sel_idx;
    logic       ack_acc;

    assign req_edge = req & ~req_q;
    assign ack_acc  = (state_q == PRESENT) && ack;
    assign clr      = ack_acc ? (8'd1 << code_q) : 8'd0;
    // Set wins over clear so an edge arriving with the ack is not lost.
    assign pend_d   = (pend_q & ~clr) | req_edge;
    assign cand     = pend_q & ~mask;

    // Last assignment in loop order wins, so the scan direction sets priority.
    always_comb begin
        sel_idx = 3'd0;
        if (MSB_FIRST) begin
            for (int i = 0; i < 8; i++)
                if (cand[i]) sel_idx = 3'(i);
        end else begin
            for (int i = 7; i >= 0; i--)
                if (cand[i]) sel_idx = 3'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= req;
            pend_q  <= 8'h00;
            code_q  <= 3'd0;
            valid_q <= 1'b0;
            state_q <= IDLE;
        end else begin
            req_q  <= req;
            pend_q <= pend_d;
            case (state_q)
                IDLE: begin
                    if (enable && (cand != 8'h00)) begin
                        code_q  <= sel_idx;
                        valid_q <= 1'b1;
                        state_q <= PRESENT;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                PRESENT: begin
                    if (ack) begin
                        valid_q <= 1'b0;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign code    = code_q;
    assign valid   = valid_q;
    assign pending = pend_q;

endmodule
